// File: rtl/mac32_arb_sched.sv
// Round-robin scheduler that feeds N_REQ requesters into one pipelined FP MAC.
// The MAC reads fp_mode live at its output, so a mode change waits until the MAC pipe is empty.
module mac32_arb_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [2*N_REQ-1:0]    req_mode_i,
  input  logic [3*N_REQ-1:0]    req_rm_i,
  input  logic [32*N_REQ-1:0]   req_a_i,
  input  logic [32*N_REQ-1:0]   req_b_i,
  input  logic [32*N_REQ-1:0]   req_c_i,
  output logic [1:0]            mac_fp_mode_o,
  output logic [2:0]            mac_rm_o,
  output logic [31:0]           mac_a_o,
  output logic [31:0]           mac_b_o,
  output logic [31:0]           mac_c_o,
  input  logic [31:0]           mac_result_i,
  input  logic                  mac_nv_i,
  input  logic                  mac_of_i,
  input  logic                  mac_uf_i,
  input  logic                  mac_nx_i,
  output logic                  resp_valid_o,
  output logic [ID_W-1:0]       resp_id_o,
  output logic [31:0]           resp_result_o,
  output logic                  resp_nv_o,
  output logic                  resp_of_o,
  output logic                  resp_uf_o,
  output logic                  resp_nx_o,
  output logic                  idle_o,
  output logic [15:0]           stall_cnt_o
);

  localparam logic [1:0]  MODE_ILL = 2'b11;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            err;
  } tag_t;

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0]      cur_mode_q, cur_mode_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;
  tag_t            s1_q, s1_d, s2_q, s2_d;
  logic            resp_valid_q, resp_valid_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;
  logic [31:0]     resp_result_q, resp_result_d;
  logic [3:0]      resp_flags_q, resp_flags_d;

  logic            found, is_err, grant, stall;
  logic [ID_W-1:0] win_id;
  logic [1:0]      win_mode;
  logic [2:0]      win_rm;
  logic [31:0]     win_a, win_b, win_c;

  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid_i[(int'(rr_ptr_q) + i) % N_REQ]) begin
        found  = 1'b1;
        win_id = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
      end
    end
  end

  assign win_mode = req_mode_i[2*int'(win_id) +: 2];
  assign win_rm   = req_rm_i[3*int'(win_id) +: 3];
  assign win_a    = req_a_i[32*int'(win_id) +: 32];
  assign win_b    = req_b_i[32*int'(win_id) +: 32];
  assign win_c    = req_c_i[32*int'(win_id) +: 32];

  // Illegal-mode ops bypass the mode lock: their MAC result is discarded anyway.
  assign is_err = (win_mode == MODE_ILL);
  assign grant  = rst_n && found &&
                  (is_err || win_mode == cur_mode_q || !(s1_q.vld || s2_q.vld));
  assign stall  = found && !grant;

  always_comb begin
    req_ready_o = '0;
    for (int k = 0; k < N_REQ; k++) req_ready_o[k] = grant && (int'(win_id) == k);
  end

  always_comb begin
    cur_mode_d  = (grant && !is_err) ? win_mode : cur_mode_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant) rr_ptr_d = (int'(win_id) == N_REQ-1) ? '0 : win_id + 1'b1;
    stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    s1_d        = '{vld: grant, id: win_id, err: is_err};
    s2_d        = s1_q;
  end

  // Mode switch takes effect in the grant cycle so the MAC samples the new mode.
  assign mac_fp_mode_o = cur_mode_d;
  assign mac_rm_o      = grant ? win_rm : 3'b0;
  assign mac_a_o       = (grant && !is_err) ? win_a : 32'b0;
  assign mac_b_o       = (grant && !is_err) ? win_b : 32'b0;
  assign mac_c_o       = (grant && !is_err) ? win_c : 32'b0;

  always_comb begin
    resp_valid_d  = s2_q.vld;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_flags_d  = resp_flags_q;
    if (s2_q.vld) begin
      resp_id_d     = s2_q.id;
      resp_result_d = s2_q.err ? QNAN : mac_result_i;
      resp_flags_d  = s2_q.err ? 4'b1000 : {mac_nv_i, mac_of_i, mac_uf_i, mac_nx_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      cur_mode_q    <= 2'b00;
      stall_cnt_q   <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      cur_mode_q    <= cur_mode_d;
      stall_cnt_q   <= stall_cnt_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_flags_q  <= resp_flags_d;
    end
  end

  assign resp_valid_o  = resp_valid_q;
  assign resp_id_o     = resp_id_q;
  assign resp_result_o = resp_result_q;
  assign {resp_nv_o, resp_of_o, resp_uf_o, resp_nx_o} = resp_flags_q;
  assign idle_o        = !(s1_q.vld || s2_q.vld || resp_valid_q);
  assign stall_cnt_o   = stall_cnt_q;

endmodule
